// File: rtl/dcpu16_wbram_pkg.sv
// ============================================================================
// Module      : dcpu16_wbram_pkg
// Description : Shared state encoding and counter width for the dcpu16 wait-
//               state RAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcpu16_wbram_pkg;

    localparam int unsigned c_cnt_w = 4;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_wait = 2'd1;
    localparam state_t c_st_ack  = 2'd2;

    // Value loaded into the wait counter when leaving IDLE; a zero wait never loads it.
    function automatic logic [c_cnt_w-1:0] wait_load(input int unsigned w);
        int unsigned v;
        v = (w > 0) ? (w - 1) : 0;
        return v[c_cnt_w-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcpu16_wbram_seq.sv
// ============================================================================
// Module      : dcpu16_wbram_seq
// Description : One strobe/ack port sequencer: IDLE/WAIT/ACK FSM with a
//               wait-state counter, a registered ack and a commit strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcpu16_wbram_seq
    import dcpu16_wbram_pkg::*;
#(
    parameter int unsigned WAIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_stb,
    output logic o_ack,
    output logic o_commit
);

    localparam logic [c_cnt_w-1:0] c_load    = wait_load(WAIT);
    localparam logic               c_no_wait = (WAIT == 0);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_ack;

    // Commit marks the edge that enters ACK; reset on the same edge suppresses it.
    always_comb begin
        o_commit = 1'b0;
        if (!rst && i_stb) begin
            case (r_state)
                c_st_idle: o_commit = c_no_wait;
                c_st_wait: o_commit = (r_cnt == '0);
                default:   o_commit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (o_commit) begin
                        r_state <= c_st_ack;
                        r_ack   <= 1'b1;
                    end else if (i_stb) begin
                        r_state <= c_st_wait;
                        r_cnt   <= c_load;
                    end
                end
                c_st_wait: begin
                    if (!i_stb) begin
                        r_state <= c_st_idle;
                    end else if (o_commit) begin
                        r_state <= c_st_ack;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_st_ack: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign o_ack = r_ack;

endmodule

`default_nettype wire

// File: rtl/dcpu16_wbram_wait.sv
// ============================================================================
// Module      : dcpu16_wbram_wait
// Description : Dual-port (fetch / access bus) RAM responder with per-port
//               wait states, read-first collisions and a collision counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcpu16_wbram_wait
    import dcpu16_wbram_pkg::*;
#(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned FS_WAIT = 0,
    parameter int unsigned AB_WAIT = 0,
    parameter int unsigned PRIO_AB = 1,
    parameter int unsigned CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fs_stb,
    input  logic          fs_wre,
    input  logic [AW-1:0] fs_adr,
    input  logic [DW-1:0] fs_dti,
    output logic [DW-1:0] fs_dto,
    output logic          fs_ack,
    input  logic          ab_stb,
    input  logic          ab_wre,
    input  logic [AW-1:0] ab_adr,
    input  logic [DW-1:0] ab_dti,
    output logic [DW-1:0] ab_dto,
    output logic          ab_ack,
    output logic [CW-1:0] col_cnt
);

    localparam logic c_prio_ab = (PRIO_AB != 0);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_fs_dto;
    logic [DW-1:0] r_ab_dto;
    logic [CW-1:0] r_col_cnt;

    logic w_fs_commit;
    logic w_ab_commit;
    logic w_same_adr;
    logic w_collide;
    logic w_fs_we;
    logic w_ab_we;

    dcpu16_wbram_seq #(
        .WAIT (FS_WAIT)
    ) u_fs_seq (
        .clk      (clk),
        .rst      (rst),
        .i_stb    (fs_stb),
        .o_ack    (fs_ack),
        .o_commit (w_fs_commit)
    );

    dcpu16_wbram_seq #(
        .WAIT (AB_WAIT)
    ) u_ab_seq (
        .clk      (clk),
        .rst      (rst),
        .i_stb    (ab_stb),
        .o_ack    (ab_ack),
        .o_commit (w_ab_commit)
    );

    assign w_same_adr = w_fs_commit && w_ab_commit && (fs_adr == ab_adr);
    assign w_collide  = w_same_adr && (fs_wre || ab_wre);

    // On a same-address double write only the priority port's write survives.
    assign w_fs_we = w_fs_commit && fs_wre && !(w_same_adr && ab_wre && c_prio_ab);
    assign w_ab_we = w_ab_commit && ab_wre && !(w_same_adr && fs_wre && !c_prio_ab);

    // Memory content is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_fs_we) begin
            r_mem[fs_adr] <= fs_dti;
        end
        if (w_ab_we) begin
            r_mem[ab_adr] <= ab_dti;
        end
    end

    // Reads sample the array before this edge's writes land: read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fs_dto  <= '0;
            r_ab_dto  <= '0;
            r_col_cnt <= '0;
        end else begin
            if (w_fs_commit && !fs_wre) begin
                r_fs_dto <= r_mem[fs_adr];
            end
            if (w_ab_commit && !ab_wre) begin
                r_ab_dto <= r_mem[ab_adr];
            end
            if (w_collide && (r_col_cnt != '1)) begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end
    end

    assign fs_dto  = r_fs_dto;
    assign ab_dto  = r_ab_dto;
    assign col_cnt = r_col_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dcpu16_wbram_wait.sv
// ============================================================================
// Module      : tb_dcpu16_wbram_wait
// Description : Self-checking bench for dcpu16_wbram_wait across three
//               parameter sets (wait states, ab priority, fs priority).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcpu16_wbram_wait;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [3];
    logic        fs_stb  [3];
    logic        fs_wre  [3];
    logic [15:0] fs_adr  [3];
    logic [15:0] fs_dti  [3];
    logic [15:0] fs_dto  [3];
    logic        fs_ack  [3];
    logic        ab_stb  [3];
    logic        ab_wre  [3];
    logic [15:0] ab_adr  [3];
    logic [15:0] ab_dti  [3];
    logic [15:0] ab_dto  [3];
    logic        ab_ack  [3];
    logic [7:0]  col_cnt [3];

    // dut 0: fs W=0, ab W=3, ab priority
    dcpu16_wbram_wait #(.AW(16), .DW(16), .FS_WAIT(0), .AB_WAIT(3), .PRIO_AB(1), .CW(8)) u_dut0 (
        .clk(clk), .rst(rst[0]),
        .fs_stb(fs_stb[0]), .fs_wre(fs_wre[0]), .fs_adr(fs_adr[0]), .fs_dti(fs_dti[0]),
        .fs_dto(fs_dto[0]), .fs_ack(fs_ack[0]),
        .ab_stb(ab_stb[0]), .ab_wre(ab_wre[0]), .ab_adr(ab_adr[0]), .ab_dti(ab_dti[0]),
        .ab_dto(ab_dto[0]), .ab_ack(ab_ack[0]), .col_cnt(col_cnt[0]));

    // dut 1: both W=0, ab priority
    dcpu16_wbram_wait #(.AW(16), .DW(16), .FS_WAIT(0), .AB_WAIT(0), .PRIO_AB(1), .CW(8)) u_dut1 (
        .clk(clk), .rst(rst[1]),
        .fs_stb(fs_stb[1]), .fs_wre(fs_wre[1]), .fs_adr(fs_adr[1]), .fs_dti(fs_dti[1]),
        .fs_dto(fs_dto[1]), .fs_ack(fs_ack[1]),
        .ab_stb(ab_stb[1]), .ab_wre(ab_wre[1]), .ab_adr(ab_adr[1]), .ab_dti(ab_dti[1]),
        .ab_dto(ab_dto[1]), .ab_ack(ab_ack[1]), .col_cnt(col_cnt[1]));

    // dut 2: both W=0, fs priority
    dcpu16_wbram_wait #(.AW(16), .DW(16), .FS_WAIT(0), .AB_WAIT(0), .PRIO_AB(0), .CW(8)) u_dut2 (
        .clk(clk), .rst(rst[2]),
        .fs_stb(fs_stb[2]), .fs_wre(fs_wre[2]), .fs_adr(fs_adr[2]), .fs_dti(fs_dti[2]),
        .fs_dto(fs_dto[2]), .fs_ack(fs_ack[2]),
        .ab_stb(ab_stb[2]), .ab_wre(ab_wre[2]), .ab_adr(ab_adr[2]), .ab_dti(ab_dti[2]),
        .ab_dto(ab_dto[2]), .ab_ack(ab_ack[2]), .col_cnt(col_cnt[2]));

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard: one queue per (dut, port); each ack pops the dto it must show.
    logic [15:0] exp_q   [6][$];
    logic [15:0] last_rd [6];
    logic [7:0]  exp_col [3];

    typedef struct {
        int          k;
        int          p;
        logic        wre;
        logic [15:0] adr;
        logic [15:0] dti;
        logic [15:0] rd;
        int          lat;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic        mon_a;
    logic [15:0] mon_d;
    always @(negedge clk) begin
        for (int mk = 0; mk < 3; mk++) begin
            for (int mp = 0; mp < 2; mp++) begin
                mon_a = (mp == 1) ? ab_ack[mk] : fs_ack[mk];
                mon_d = (mp == 1) ? ab_dto[mk] : fs_dto[mk];
                if (mon_a) begin
                    if (exp_q[mk*2+mp].size() == 0)
                        check($sformatf("unexpected_ack_d%0d_p%0d", mk, mp), 32'(mon_a), 32'(0));
                    else
                        check($sformatf("dto_d%0d_p%0d", mk, mp), 32'(mon_d), 32'(exp_q[mk*2+mp].pop_front()));
                end
            end
        end
    end

    task automatic drive(input int k, input int p, input logic stb, input logic wre,
                         input logic [15:0] adr, input logic [15:0] dti);
        if (p == 0) begin
            fs_stb[k] = stb; fs_wre[k] = wre; fs_adr[k] = adr; fs_dti[k] = dti;
        end else begin
            ab_stb[k] = stb; ab_wre[k] = wre; ab_adr[k] = adr; ab_dti[k] = dti;
        end
    endtask

    function automatic logic get_ack(input int k, input int p);
        return (p == 1) ? ab_ack[k] : fs_ack[k];
    endfunction

    task automatic expect_resp(input int k, input int p, input logic wre, input logic [15:0] rd);
        if (wre) begin
            exp_q[k*2+p].push_back(last_rd[k*2+p]);
        end else begin
            exp_q[k*2+p].push_back(rd);
            last_rd[k*2+p] = rd;
        end
    endtask

    task automatic txn(input int k, input int p, input logic wre, input logic [15:0] adr,
                       input logic [15:0] dti, input logic [15:0] rd, input int lat, input string name);
        int n;
        n = 0;
        expect_resp(k, p, wre, rd);
        drive(k, p, 1'b1, wre, adr, dti);
        do begin
            @(negedge clk);
            n++;
        end while (!get_ack(k, p) && n < 40);
        check({name, "_latency"}, 32'(n), 32'(lat));
        drive(k, p, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
    endtask

    // Both ports of a zero-wait dut commit on the same edge.
    task automatic collide(input int k, input logic [15:0] adr,
                           input logic fwre, input logic [15:0] fdti, input logic [15:0] frd,
                           input logic awre, input logic [15:0] adti, input logic [15:0] ard);
        expect_resp(k, 0, fwre, frd);
        expect_resp(k, 1, awre, ard);
        drive(k, 0, 1'b1, fwre, adr, fdti);
        drive(k, 1, 1'b1, awre, adr, adti);
        @(negedge clk);
        check("collide_fs_ack", 32'(fs_ack[k]), 32'(1));
        check("collide_ab_ack", 32'(ab_ack[k]), 32'(1));
        if ((fwre || awre) && exp_col[k] != 8'hFF) exp_col[k] = exp_col[k] + 8'd1;
        drive(k, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(k, 1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            exp_col[i] = 8'h00;
            drive(i, 0, 1'b0, 1'b0, 16'h0, 16'h0);
            drive(i, 1, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        for (int i = 0; i < 6; i++) last_rd[i] = 16'h0;

        tbl[0] = '{0, 0, 1'b1, 16'h0010, 16'h7C01, 16'h0000, 1};
        tbl[1] = '{0, 0, 1'b0, 16'h0010, 16'h0000, 16'h7C01, 1};
        tbl[2] = '{0, 1, 1'b1, 16'h0100, 16'hBEEF, 16'h0000, 4};
        tbl[3] = '{0, 1, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 4};
        tbl[4] = '{0, 1, 1'b1, 16'h0200, 16'h0000, 16'h0000, 4};
        tbl[5] = '{0, 1, 1'b1, 16'h0500, 16'h0055, 16'h0000, 4};
        tbl[6] = '{1, 0, 1'b1, 16'h0400, 16'hAAAA, 16'h0000, 1};
        tbl[7] = '{1, 1, 1'b0, 16'h0400, 16'h0000, 16'hAAAA, 1};
        tbl[8] = '{2, 1, 1'b1, 16'h0600, 16'hC0DE, 16'h0000, 1};
        tbl[9] = '{2, 0, 1'b0, 16'h0600, 16'h0000, 16'hC0DE, 1};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_fs_ack", 32'(fs_ack[i]), 32'(0));
            check("reset_ab_ack", 32'(ab_ack[i]), 32'(0));
            check("reset_fs_dto", 32'(fs_dto[i]), 32'(0));
            check("reset_ab_dto", 32'(ab_dto[i]), 32'(0));
            check("reset_col_cnt", 32'(col_cnt[i]), 32'(0));
            rst[i] = 1'b0;
        end
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            txn(tbl[i].k, tbl[i].p, tbl[i].wre, tbl[i].adr, tbl[i].dti, tbl[i].rd, tbl[i].lat,
                $sformatf("vec%0d", i));

        // Legacy 1-on/1-off ack with fs_stb held high on a zero-wait port.
        for (int i = 0; i < 4; i++) expect_resp(0, 0, 1'b0, 16'h7C01);
        drive(0, 0, 1'b1, 1'b0, 16'h0010, 16'h0);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check($sformatf("legacy_ack_c%0d", n), 32'(fs_ack[0]), 32'(n % 2));
        end
        drive(0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);

        // Abort: drop ab_stb during WAIT of a write.
        drive(0, 1, 1'b1, 1'b1, 16'h0200, 16'h1234);
        repeat (2) @(negedge clk);
        drive(0, 1, 1'b0, 1'b0, 16'h0, 16'h0);
        acks = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (ab_ack[0]) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'(0));
        txn(0, 1, 1'b0, 16'h0200, 16'h0, 16'h0000, 4, "abort_readback");

        // Same-edge double writes under each priority.
        collide(1, 16'h0300, 1'b1, 16'h1111, 16'h0, 1'b1, 16'h2222, 16'h0);
        check("col_cnt_prio_ab", 32'(col_cnt[1]), 32'(exp_col[1]));
        txn(1, 0, 1'b0, 16'h0300, 16'h0, 16'h2222, 1, "prio_ab_readback");
        collide(2, 16'h0300, 1'b1, 16'h1111, 16'h0, 1'b1, 16'h2222, 16'h0);
        check("col_cnt_prio_fs", 32'(col_cnt[2]), 32'(exp_col[2]));
        txn(2, 0, 1'b0, 16'h0300, 16'h0, 16'h1111, 1, "prio_fs_readback");

        // Read-first across ports, then a same-address double read (not a collision).
        collide(1, 16'h0400, 1'b0, 16'h0, 16'hAAAA, 1'b1, 16'h5555, 16'h0);
        check("col_cnt_read_first", 32'(col_cnt[1]), 32'(exp_col[1]));
        txn(1, 0, 1'b0, 16'h0400, 16'h0, 16'h5555, 1, "read_first_readback");
        collide(2, 16'h0600, 1'b0, 16'h0, 16'hC0DE, 1'b0, 16'h0, 16'hC0DE);
        check("col_cnt_double_read", 32'(col_cnt[2]), 32'(exp_col[2]));

        // Reset during WAIT of a write on the slow port.
        drive(0, 1, 1'b1, 1'b1, 16'h0500, 16'h9999);
        repeat (2) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        check("rst_wait_ab_ack", 32'(ab_ack[0]), 32'(0));
        check("rst_wait_fs_ack", 32'(fs_ack[0]), 32'(0));
        check("rst_wait_fs_dto", 32'(fs_dto[0]), 32'(0));
        check("rst_wait_ab_dto", 32'(ab_dto[0]), 32'(0));
        check("rst_wait_col_cnt", 32'(col_cnt[0]), 32'(0));
        last_rd[0] = 16'h0; last_rd[1] = 16'h0; exp_col[0] = 8'h00;
        rst[0] = 1'b0;
        drive(0, 1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        txn(0, 1, 1'b0, 16'h0500, 16'h0, 16'h0055, 4, "rst_wait_readback");

        // Reset on the edge that would commit a zero-wait write blocks it.
        txn(1, 0, 1'b1, 16'h0700, 16'h0001, 16'h0, 1, "rst_commit_prewrite");
        rst[1] = 1'b1;
        drive(1, 0, 1'b1, 1'b1, 16'h0700, 16'h7777);
        @(negedge clk);
        check("rst_commit_fs_ack", 32'(fs_ack[1]), 32'(0));
        check("rst_commit_col_cnt", 32'(col_cnt[1]), 32'(0));
        last_rd[2] = 16'h0; last_rd[3] = 16'h0; exp_col[1] = 8'h00;
        rst[1] = 1'b0;
        drive(1, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        txn(1, 0, 1'b0, 16'h0700, 16'h0, 16'h0001, 1, "rst_commit_readback");

        // Collision counter saturation.
        for (int i = 0; i < 300; i++) begin
            collide(2, 16'h0800, 1'b1, 16'(i), 16'h0, 1'b1, ~16'(i), 16'h0);
            if (i == 100) check("col_cnt_mid", 32'(col_cnt[2]), 32'(exp_col[2]));
        end
        check("col_cnt_saturated", 32'(col_cnt[2]), 32'(8'hFF));
        txn(2, 0, 1'b0, 16'h0800, 16'h0, 16'h012B, 1, "saturate_readback");

        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++)
            check($sformatf("queue_empty_%0d", i), 32'(exp_q[i].size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
